// File: rtl/reg_access_pkg.sv
// reg_access_pkg
// Shared definitions for the register-access controller:
//   - state_t      : controller FSM states
//   - OPCODE_RTYPE : opcode value that selects the rd destination field
//   - *_MSB/*_LSB  : MIPS instruction field bit positions
//   - dest_field() : picks the destination register index from an instruction
package reg_access_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        EXEC    = 3'd3,
        WRITE   = 3'd4
    } state_t;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    // R-type instructions write rd; every other format writes rt.
    function automatic logic [4:0] dest_field(input logic [31:0] word);
        if (word[OP_MSB:OP_LSB] == OPCODE_RTYPE)
            return word[RD_MSB:RD_LSB];
        else
            return word[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer
// Counts EXEC cycles spent waiting for the ALU and flags the final
// permitted cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count back to zero (any non-waiting state)
//   enable     : count one more waiting cycle
//   expired    : high during the MAX_WAIT-th waiting cycle
module wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

    // The count holds the number of cycles already completed, so the
    // current cycle is the MAX_WAIT-th one when count equals MAX_WAIT-1.
    assign expired = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl
// Sequences one MIPS-style register operation: reads two source registers
// from an external bank, hands them to an external ALU, waits (bounded) for
// the result and writes it back to the destination register.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   instr, instr_valid      : instruction offer; instr_ready high only in IDLE
//   rd_addr1/2, rd_data1/2  : bank read ports
//   wr_addr, wr_data, wr_en : bank write port
//   op_a, op_b, op_valid    : operands to the ALU
//   alu_result, alu_valid   : ALU response
//   done, err               : one-cycle completion / timeout pulses
// Build option: REG_ZERO_GUARD_EN suppresses writes to register index 0
// (done still pulses).
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_valid,
    output logic              done,
    output logic              err
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] result;
    logic              accept;
    logic              expired;

    assign accept = instr_valid && instr_ready;

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != EXEC),
        .enable  (state == EXEC),
        .expired (expired)
    );

    // State and datapath registers. The destination index is decoded at
    // accept time so the rest of the instruction need not be kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            dest     <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rd_addr1 <= ADDR_W'(instr[RS_MSB:RS_LSB]);
                rd_addr2 <= ADDR_W'(instr[RT_MSB:RT_LSB]);
                dest     <= ADDR_W'(dest_field(instr));
            end
            if (state == CAPTURE) begin
                op_a <= rd_data1;
                op_b <= rd_data2;
            end
            if (state == EXEC && alu_valid)
                result <= alu_result;
        end
    end

    // Next state and outputs. READ exists only to let the bank's read data
    // settle; an ALU response in the last permitted EXEC cycle beats the
    // timeout. instr_ready is also held low while reset is asserted.
    always_comb begin
        state_next  = state;
        instr_ready = 1'b0;
        op_valid    = 1'b0;
        wr_en       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = rst_n;
                if (instr_valid && rst_n)
                    state_next = READ;
            end
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = EXEC;
            EXEC: begin
                op_valid = 1'b1;
                if (alu_valid) begin
                    state_next = WRITE;
                end else if (expired) begin
                    err        = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                done = 1'b1;
`ifdef REG_ZERO_GUARD_EN
                wr_en = (dest != '0);
`else
                wr_en = 1'b1;
`endif
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_addr = dest;
    assign wr_data = result;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb_reg_access_ctrl
// Directed self-checking bench for reg_access_ctrl. A small register bank
// array answers the read ports; the ALU response is driven by hand.
// Honours REG_ZERO_GUARD_EN when checking writes to register 0.
module tb_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr;
    logic [31:0] rd_data1, rd_data2, wr_data;
    logic        wr_en;
    logic [31:0] op_a, op_b;
    logic        op_valid;
    logic [31:0] alu_result = '0;
    logic        alu_valid = 1'b0;
    logic        done, err;

    logic [31:0] bank [32];
    int          checks = 0;
    int          errors = 0;

    assign rd_data1 = bank[rd_addr1];
    assign rd_data2 = bank[rd_addr2];

    always #5 clk = ~clk;

    reg_access_ctrl #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_valid    (op_valid),
        .alu_result  (alu_result),
        .alu_valid   (alu_valid),
        .done        (done),
        .err         (err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction for a single cycle; returns in the READ cycle.
    task automatic applyStimulus(input logic [31:0] word);
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        int early;
        int accepts;
        int dones;
        int writes;

        for (int i = 0; i < 32; i++) bank[i] = 32'h100 + i;
        bank[9]  = 32'd5;
        bank[10] = 32'd7;
        bank[1]  = 32'h11;
        bank[3]  = 32'h33;

        // Reset values
        #12;
        checkOutput("rst_instr_ready", instr_ready, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_op_valid", op_valid, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_rd_addr1", rd_addr1, 0);
        checkOutput("rst_wr_data", wr_data, 0);
        checkOutput("rst_op_a", op_a, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        checkOutput("idle_ready", instr_ready, 1);

        // R-type add r8 = r9 + r10, ALU answers in the second EXEC cycle
        applyStimulus(32'h012A4020);
        checkOutput("rt_read_ready", instr_ready, 0);
        checkOutput("rt_rd_addr1", rd_addr1, 9);
        checkOutput("rt_rd_addr2", rd_addr2, 10);
        tick();
        checkOutput("rt_capture_opvalid", op_valid, 0);
        tick();
        checkOutput("rt_exec_opvalid", op_valid, 1);
        checkOutput("rt_op_a", op_a, 5);
        checkOutput("rt_op_b", op_b, 7);
        checkOutput("rt_exec1_done", done, 0);
        tick();
        alu_valid  = 1'b1;
        alu_result = 32'd12;
        checkOutput("rt_exec2_opvalid", op_valid, 1);
        tick();
        alu_valid = 1'b0;
        checkOutput("rt_wr_en", wr_en, 1);
        checkOutput("rt_done", done, 1);
        checkOutput("rt_wr_addr", wr_addr, 8);
        checkOutput("rt_wr_data", wr_data, 12);
        tick();
        checkOutput("rt_after_wr_en", wr_en, 0);
        checkOutput("rt_after_done", done, 0);
        checkOutput("rt_after_ready", instr_ready, 1);

        // I-type (opcode 0x08) writes rt=3, ALU answers in the first EXEC cycle
        applyStimulus(32'h20230004);
        tick();
        alu_valid  = 1'b1;
        alu_result = 32'hFFFF0000;
        tick();
        checkOutput("it_op_a", op_a, 32'h11);
        checkOutput("it_op_b", op_b, 32'h33);
        tick();
        alu_valid = 1'b0;
        checkOutput("it_wr_en", wr_en, 1);
        checkOutput("it_done", done, 1);
        checkOutput("it_wr_addr", wr_addr, 3);
        checkOutput("it_wr_data", wr_data, 32'hFFFF0000);
        tick();

        // Timeout: no ALU response for 15 EXEC cycles
        applyStimulus(32'h00430820);
        tick();
        tick();
        early = 0;
        for (int k = 1; k < 15; k++) begin
            if (err || wr_en || !op_valid) early++;
            tick();
        end
        checkOutput("to_early_events", early, 0);
        checkOutput("to_err", err, 1);
        checkOutput("to_op_valid_last", op_valid, 1);
        checkOutput("to_wr_en", wr_en, 0);
        checkOutput("to_ready_during", instr_ready, 0);
        tick();
        checkOutput("to_err_cleared", err, 0);
        checkOutput("to_ready_back", instr_ready, 1);
        checkOutput("to_no_write", wr_en, 0);
        checkOutput("to_no_done", done, 0);

        // ALU response in the very last permitted cycle wins over timeout
        applyStimulus(32'h00430820);
        tick();
        tick();
        for (int k = 1; k < 15; k++) tick();
        alu_valid  = 1'b1;
        alu_result = 32'h0000ABCD;
        #1;
        checkOutput("edge_no_err", err, 0);
        tick();
        alu_valid = 1'b0;
        checkOutput("edge_done", done, 1);
        checkOutput("edge_wr_en", wr_en, 1);
        checkOutput("edge_wr_addr", wr_addr, 1);
        checkOutput("edge_wr_data", wr_data, 32'h0000ABCD);
        tick();

        // Reset asserted during EXEC aborts with no write
        applyStimulus(32'h012A4020);
        tick();
        tick();
        checkOutput("ar_in_exec", op_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_op_valid", op_valid, 0);
        checkOutput("ar_op_a", op_a, 0);
        checkOutput("ar_op_b", op_b, 0);
        checkOutput("ar_rd_addr1", rd_addr1, 0);
        checkOutput("ar_wr_en", wr_en, 0);
        checkOutput("ar_done", done, 0);
        checkOutput("ar_ready", instr_ready, 0);
        alu_valid  = 1'b1;
        alu_result = 32'h55;
        @(negedge clk) rst_n = 1'b1;
        writes = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (wr_en || done) writes++;
        end
        alu_valid = 1'b0;
        checkOutput("ar_no_write_after", writes, 0);
        checkOutput("ar_idle_ready", instr_ready, 1);

        // Destination register 0 (R-type, rd=0)
        applyStimulus(32'h00850020);
        tick();
        alu_valid  = 1'b1;
        alu_result = 32'h77;
        tick();
        tick();
        alu_valid = 1'b0;
        checkOutput("z_done", done, 1);
        checkOutput("z_wr_addr", wr_addr, 0);
`ifdef REG_ZERO_GUARD_EN
        checkOutput("z_wr_en", wr_en, 0);
`else
        checkOutput("z_wr_en", wr_en, 1);
`endif
        tick();

        // instr_valid held high: one accept per completion, 5-cycle cadence
        instr       = 32'h012A4020;
        instr_valid = 1'b1;
        alu_valid   = 1'b1;
        alu_result  = 32'h99;
        accepts = 0;
        dones   = 0;
        for (int i = 0; i < 20; i++) begin
            checkOutput("bb_ready_cycle", instr_ready, (i % 5 == 0) ? 1 : 0);
            if (instr_ready) accepts++;
            if (done) dones++;
            tick();
        end
        instr_valid = 1'b0;
        alu_valid   = 1'b0;
        checkOutput("bb_accepts", accepts, 4);
        checkOutput("bb_dones", dones, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
